sseg_capture: RTL

//  Receive side of the multiplexed 7-segment bus (active-low digit select + active-low segments).

---
 rtl/sseg_capture_pkg.sv | 48 ++++
 rtl/sseg_pattern_decode.sv | 34 +++
 rtl/sseg_capture.sv | 102 ++++++++++
 3 files changed

// File: rtl/sseg_capture_pkg.sv
// rtl/sseg_capture_pkg.sv - shared 7-segment tables and polarity constants
package sseg_capture_pkg;

  localparam int SEG_DP = 0;
  localparam logic ACTIVE_LOW_SEL = 1'b1;
  localparam logic ACTIVE_LOW_SEG = 1'b1;

  // abcdefg, active-high; the display driver encodes from the same table
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;

  typedef enum logic [1:0] {
    SEL_BLANK = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_kind_e;

  function automatic sel_kind_e classify_sel(input logic [3:0] sel_on);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 4; i++) n += int'(sel_on[i]);
    if (n == 0) return SEL_BLANK;
    if (n == 1) return SEL_ONE;
    return SEL_MULTI;
  endfunction

  function automatic logic [1:0] sel_index(input logic [3:0] sel_on);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) if (sel_on[i]) idx = 2'(i);
    return idx;
  endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// rtl/sseg_pattern_decode.sv - active-high abcdefg pattern to hex digit
module sseg_pattern_decode
  import sseg_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] hex
);

  always_comb begin
    hit = 1'b1;
    hex = 4'h0;
    case (pattern)
      SEG_0:   hex = 4'h0;
      SEG_1:   hex = 4'h1;
      SEG_2:   hex = 4'h2;
      SEG_3:   hex = 4'h3;
      SEG_4:   hex = 4'h4;
      SEG_5:   hex = 4'h5;
      SEG_6:   hex = 4'h6;
      SEG_7:   hex = 4'h7;
      SEG_8:   hex = 4'h8;
      SEG_9:   hex = 4'h9;
      SEG_A:   hex = 4'hA;
      SEG_B:   hex = 4'hB;
      SEG_C:   hex = 4'hC;
      SEG_D:   hex = 4'hD;
      SEG_E:   hex = 4'hE;
      SEG_F:   hex = 4'hF;
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_capture.sv
// rtl/sseg_capture.sv - filters and decodes a multiplexed 7-segment bus back to hex digits
module sseg_capture
  import sseg_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  disp_select,
  input  logic [7:0]  seven_value,
  input  logic        err_clr,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic [3:0]  digit_valid,
  output logic        frame_strobe,
  output logic        seg_error,
  output logic        sel_error
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(SETTLE_CYCLES - 1);

  logic [3:0]       sel_q, sel_d;
  logic [7:0]       seg_q, seg_d;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       seen;

  logic       match, capture;
  logic [3:0] sel_on;
  logic [7:0] seg_on;
  sel_kind_e  sel_kind;
  logic [1:0] idx;
  logic       hit;
  logic [3:0] hex;
  logic       digit_load, seg_err_set, sel_err_set;
  logic [3:0] seen_next;

  assign match   = (sel_q == sel_d) && (seg_q == seg_d);
  assign capture = match && (cnt == CNT_CAP);

  assign sel_on   = ACTIVE_LOW_SEL ? ~sel_q : sel_q;
  assign seg_on   = ACTIVE_LOW_SEG ? ~seg_q : seg_q;
  assign sel_kind = classify_sel(sel_on);
  assign idx      = sel_index(sel_on);

  sseg_pattern_decode u_decode (
    .pattern (seg_on[7:1]),
    .hit     (hit),
    .hex     (hex)
  );

  assign digit_load  = capture && (sel_kind == SEL_ONE) && hit;
  assign seg_err_set = capture && (sel_kind == SEL_ONE) && !hit;
  assign sel_err_set = capture && (sel_kind == SEL_MULTI);
  assign seen_next   = seen | (4'b0001 << idx);

  always_ff @(posedge clk) begin
    if (!reset) begin
      sel_q        <= '0;
      sel_d        <= '0;
      seg_q        <= '0;
      seg_d        <= '0;
      cnt          <= '0;
      seen         <= '0;
      digits       <= '0;
      dp           <= '0;
      digit_valid  <= '0;
      frame_strobe <= 1'b0;
      seg_error    <= 1'b0;
      sel_error    <= 1'b0;
    end else begin
      sel_q <= disp_select;
      seg_q <= seven_value;
      sel_d <= sel_q;
      seg_d <= seg_q;

      // saturating so capture fires only once per stable period
      if (!match)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      frame_strobe <= 1'b0;
      seg_error    <= (seg_error && !err_clr) || seg_err_set;
      sel_error    <= (sel_error && !err_clr) || sel_err_set;

      if (digit_load) begin
        digits[{idx, 2'b00} +: 4] <= hex;
        dp[idx]                   <= seg_on[SEG_DP];
        digit_valid[idx]          <= 1'b1;
        if (seen_next == 4'b1111) begin
          frame_strobe <= 1'b1;
          seen         <= '0;
        end else begin
          seen <= seen_next;
        end
      end
    end
  end

endmodule
